// File: rtl/reg_file_mp.sv
// Multi-port register file with optional zero register, write-to-read bypass
// and a sequential bulk-clear engine that zeroes one entry per cycle.
module reg_file_mp #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned NUM_RD   = 2,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1,
    localparam int unsigned ADDR_W  = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     reg_write,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    input  logic                     clear_req,
    output logic                     busy,
    output logic                     clear_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   cnt, cnt_nxt;
    logic                busy_nxt, clear_done_nxt;
    logic [DATA_W-1:0]   regs [DEPTH];
    logic                wr_en_c;

    // Write is accepted only in IDLE, for an in-range address, never to a hardwired zero.
    assign wr_en_c = (state == IDLE) && reg_write
                   && ({1'b0, waddr} < (ADDR_W+1)'(DEPTH))
                   && !(ZERO_REG && (waddr == '0));

    // State, counter and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            busy       <= 1'b0;
            clear_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            busy       <= busy_nxt;
            clear_done <= clear_done_nxt;
        end
    end

    // Next-state: clear walks every entry once, then announces completion for one cycle.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (clear_req) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end
            end
            CLEAR: begin
                if (cnt == ADDR_W'(DEPTH - 1)) begin
                    state_nxt = DONE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + ADDR_W'(1);
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs decoded from the upcoming state so they register alongside it.
    always_comb begin
        busy_nxt       = 1'b0;
        clear_done_nxt = 1'b0;
        case (state_nxt)
            CLEAR:   busy_nxt = 1'b1;
            DONE: begin
                busy_nxt       = 1'b1;
                clear_done_nxt = 1'b1;
            end
            default: ;
        endcase
    end

    // Storage array; clear engine and normal writes are mutually exclusive by state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs[i] <= '0;
            end
        end else if (state == CLEAR) begin
            regs[cnt] <= '0;
        end else if (wr_en_c) begin
            regs[waddr] <= wdata;
        end
    end

    for (genvar i = 0; i < int'(NUM_RD); i++) begin : g_rd
        logic [ADDR_W-1:0] ra_c;
        logic [DATA_W-1:0] rd_c;

        assign ra_c = raddr[i*ADDR_W +: ADDR_W];

        always_comb begin
            rd_c = '0;
            if (BYPASS && wr_en_c && (ra_c == waddr)) begin
                rd_c = wdata;
            end else if (({1'b0, ra_c} < (ADDR_W+1)'(DEPTH)) && !(ZERO_REG && (ra_c == '0))) begin
                rd_c = regs[ra_c];
            end
        end

        assign rdata[i*DATA_W +: DATA_W] = rd_c;
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed self-checking bench for reg_file_mp: a bypassing and a non-bypassing
// three-port instance driven with identical stimulus.
module tb_reg_file_mp;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned NR = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              reg_write;
    logic [AW-1:0]     waddr;
    logic [DW-1:0]     wdata;
    logic [NR*AW-1:0]  raddr;
    logic              clear_req;
    logic [NR*DW-1:0]  rdata_b, rdata_n;
    logic              busy_b, busy_n, done_b, done_n;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    reg_file_mp #(.DATA_W(32), .DEPTH(32), .NUM_RD(3), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
        .clk(clk), .reset(reset), .reg_write(reg_write), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata_b), .clear_req(clear_req), .busy(busy_b),
        .clear_done(done_b)
    );

    reg_file_mp #(.DATA_W(32), .DEPTH(32), .NUM_RD(3), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .reset(reset), .reg_write(reg_write), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata_n), .clear_req(clear_req), .busy(busy_n),
        .clear_done(done_n)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] port_b(input int i);
        return rdata_b[i*32 +: 32];
    endfunction

    function automatic logic [31:0] port_n(input int i);
        return rdata_n[i*32 +: 32];
    endfunction

    task automatic set_raddr(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
        raddr = {a2, a1, a0};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        reg_write = 1'b1;
        waddr     = a;
        wdata     = d;
        step();
        reg_write = 1'b0;
    endtask

    initial begin
        int k;
        int busy_cycles;
        int done_cnt;
        int done_at;

        reset     = 1'b1;
        reg_write = 1'b0;
        waddr     = '0;
        wdata     = '0;
        clear_req = 1'b0;
        set_raddr(5'd0, 5'd0, 5'd0);

        // Reset held three cycles.
        repeat (3) step();
        set_raddr(5'd1, 5'd17, 5'd31);
        #1;
        check("rst_rdata0", port_b(0), 32'h0);
        check("rst_rdata2", port_b(2), 32'h0);
        check("rst_busy", 32'(busy_b), 32'h0);
        check("rst_done", 32'(done_b), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        step();
        for (int a = 0; a < 32; a++) begin
            set_raddr(5'(a), 5'(31 - a), 5'(a));
            #1;
            check($sformatf("post_rst_rd%0d", a), port_b(0) | port_b(1) | port_n(2), 32'h0);
        end

        // Basic write/read and multi-port independence.
        write_reg(5'd21, 32'h0F0F0F0F);
        set_raddr(5'd21, 5'd0, 5'd5);
        #1;
        check("rd21_p0", port_b(0), 32'h0F0F0F0F);
        check("rd0_p1", port_b(1), 32'h0);
        check("rd5_p2", port_b(2), 32'h0);
        check("rd21_nb", port_n(0), 32'h0F0F0F0F);

        // Register 0 is hardwired to zero, including through the bypass path.
        reg_write = 1'b1; waddr = 5'd0; wdata = 32'h222222FF;
        set_raddr(5'd0, 5'd0, 5'd0);
        #1;
        check("zero_bypass", port_b(0), 32'h0);
        step();
        reg_write = 1'b0;
        #1;
        check("zero_after", port_b(1), 32'h0);

        // Same-cycle bypass on all ports vs. no bypass.
        set_raddr(5'd5, 5'd5, 5'd5);
        reg_write = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
        #1;
        check("byp_p0", port_b(0), 32'hDEADBEEF);
        check("byp_p1", port_b(1), 32'hDEADBEEF);
        check("byp_p2", port_b(2), 32'hDEADBEEF);
        check("nobyp_p0_pre", port_n(0), 32'h0);
        check("nobyp_p2_pre", port_n(2), 32'h0);
        step();
        reg_write = 1'b0;
        #1;
        check("nobyp_p0_post", port_n(0), 32'hDEADBEEF);
        check("nobyp_p1_post", port_n(1), 32'hDEADBEEF);
        check("byp_p2_post", port_b(2), 32'hDEADBEEF);

        // Write enable gating.
        reg_write = 1'b0; waddr = 5'd1; wdata = 32'h222222FF;
        step();
        set_raddr(5'd1, 5'd1, 5'd1);
        #1;
        check("wdis_rd1", port_b(0), 32'h0);
        write_reg(5'd1, 32'h222222FF);
        #1;
        check("wen_rd1", port_b(0), 32'h222222FF);

        // Fill 1..31 with their index, then bulk clear.
        for (int a = 1; a < 32; a++) write_reg(5'(a), 32'(a));
        set_raddr(5'd31, 5'd3, 5'd1);
        #1;
        check("fill_rd31", port_b(0), 32'd31);
        check("fill_rd3", port_b(1), 32'd3);
        check("fill_rd1", port_n(2), 32'd1);

        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        k = 0; busy_cycles = 0; done_cnt = 0; done_at = -1;
        while (k < 200) begin
            if (k == 10) begin
                reg_write = 1'b1; waddr = 5'd3; wdata = 32'h1234;
                set_raddr(5'd3, 5'd31, 5'd3);
            end
            if (k == 15) clear_req = 1'b1;
            @(negedge clk);
            if (!busy_b) break;
            busy_cycles++;
            if (done_b) begin
                done_cnt++;
                done_at = k;
            end
            if (k == 10) begin
                check("mid_no_bypass", port_b(0), 32'h0);
                check("mid_old_rd31", port_b(1), 32'd31);
            end
            step();
            reg_write = 1'b0;
            clear_req = 1'b0;
            k++;
        end
        check("clr_bounded", 32'(k < 200), 32'h1);
        check("clr_busy_cycles", 32'(busy_cycles), 32'd33);
        check("clr_done_count", 32'(done_cnt), 32'd1);
        check("clr_done_at", 32'(done_at), 32'd32);
        check("clr_nb_busy", 32'(busy_n), 32'h0);
        for (int a = 0; a < 32; a++) begin
            set_raddr(5'(a), 5'(a), 5'(a));
            #1;
            check($sformatf("clr_rd%0d", a), port_b(0) | port_n(1), 32'h0);
        end

        // Reset in the middle of a clear.
        step();
        write_reg(5'd20, 32'd20);
        write_reg(5'd7, 32'd7);
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        repeat (10) step();
        check("mid_busy_pre_rst", 32'(busy_b), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_busy", 32'(busy_b), 32'h0);
        check("rst_mid_done", 32'(done_b), 32'h0);
        set_raddr(5'd20, 5'd7, 5'd20);
        #1;
        check("rst_mid_rd20", port_b(0), 32'h0);
        check("rst_mid_rd7", port_n(1), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        step();
        check("post_rst_idle", 32'(busy_b), 32'h0);
        write_reg(5'd7, 32'h55);
        #1;
        check("post_rst_wr7", port_b(1), 32'h55);
        check("post_rst_wr7_nb", port_n(1), 32'h55);
        check("post_rst_busy", 32'(busy_b), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
